// File: rtl/half_duplex_pad_ctrl.sv
// Half-duplex pad controller: drives a word out MSB first, turns the bus around, samples a reply.
// Optional even-parity bit in both directions when PAD_CTRL_PARITY_EN is defined.
module half_duplex_pad_ctrl #(
    parameter int W        = 8,
    parameter int BIT_CYC  = 4,
    parameter int TURN_CYC = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic [W-1:0] rx_data,
    output logic         rx_valid,
    output logic         busy,
    output logic         parity_err,
    output logic         pad_a,
    output logic         pad_oe,
    output logic         pad_ie,
    input  logic         pad_y
);

`ifdef PAD_CTRL_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    localparam int BCW = $clog2(BIT_CYC);
    localparam int NBW = $clog2(NB);
    localparam int TCW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    localparam logic [BCW-1:0] BIT_LAST  = BCW'(BIT_CYC - 1);
    localparam logic [BCW-1:0] BIT_MID   = BCW'(BIT_CYC / 2);
    localparam logic [NBW-1:0] IDX_LAST  = NBW'(NB - 1);
    localparam logic [TCW-1:0] TURN_LAST = TCW'(TURN_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        TURN_A,
        SAMPLE,
        TURN_B
    } state_t;

    state_t         state;
    logic [BCW-1:0] bit_cnt;
    logic [NBW-1:0] bit_idx;
    logic [TCW-1:0] turn_cnt;
    logic [NB-1:0]  tx_shift;
    logic [NB-1:0]  rx_shift;
    logic [NB-1:0]  tx_word;

`ifdef PAD_CTRL_PARITY_EN
    assign tx_word = {tx_data, ^tx_data};
`else
    assign tx_word = tx_data;
    assign parity_err = 1'b0;
`endif

    // The shifter MSB is the pad data flop; it empties to zero after NB shifts, so pad_a idles low.
    assign pad_a = tx_shift[NB-1];

    // NOTE: every register here uses non-blocking assignment so all of them update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pad_oe   <= 1'b0;
            pad_ie   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            turn_cnt <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
`ifdef PAD_CTRL_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        state    <= DRIVE;
                        tx_shift <= tx_word;
                        pad_oe   <= 1'b1;
                        busy     <= 1'b1;
                        tx_ready <= 1'b0;
                        bit_cnt  <= '0;
                        bit_idx  <= '0;
                    end
                end
                DRIVE: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        tx_shift <= {tx_shift[NB-2:0], 1'b0};
                        if (bit_idx == IDX_LAST) begin
                            state    <= TURN_A;
                            pad_oe   <= 1'b0;
                            turn_cnt <= '0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                TURN_A: begin
                    if (turn_cnt == TURN_LAST) begin
                        state   <= SAMPLE;
                        pad_ie  <= 1'b1;
                        bit_cnt <= '0;
                        bit_idx <= '0;
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    // Mid-bit sampling; may coincide with the bit's last cycle when BIT_CYC is 2.
                    if (bit_cnt == BIT_MID) begin
                        rx_shift <= {rx_shift[NB-2:0], pad_y};
                    end
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            state    <= TURN_B;
                            pad_ie   <= 1'b0;
                            turn_cnt <= '0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                TURN_B: begin
                    if (turn_cnt == TURN_LAST) begin
                        state    <= IDLE;
                        rx_data  <= rx_shift[NB-1 -: W];
                        rx_valid <= 1'b1;
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
`ifdef PAD_CTRL_PARITY_EN
                        // Even parity over data plus parity bit: any odd count flags an error.
                        parity_err <= ^rx_shift;
`endif
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
